// File: rtl/ucsbece154b_pipe_ctrl.sv
// Five-stage pipeline controller: decode, D/E/M/W control pipeline, forwarding, hazards and memory-wait watchdog.
// Define UCSBECE154B_BRANCH_EXT_EN to decode bne/blt/bge/bltu/bgeu in addition to beq.
module ucsbece154b_pipe_ctrl #(
   parameter int REG_AW      = 5,
   parameter int MEM_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [6:0]        op_i,
   input  logic [2:0]        funct3_i,
   input  logic              funct7b5_i,
   input  logic              ZeroE_i,
   input  logic              LtE_i,
   input  logic              LtuE_i,
   input  logic [REG_AW-1:0] Rs1D_i,
   input  logic [REG_AW-1:0] Rs2D_i,
   input  logic [REG_AW-1:0] Rs1E_i,
   input  logic [REG_AW-1:0] Rs2E_i,
   input  logic [REG_AW-1:0] RdE_i,
   input  logic [REG_AW-1:0] RdM_i,
   input  logic [REG_AW-1:0] RdW_i,
   input  logic              DMemReady_i,
   output logic              StallF_o,
   output logic              StallD_o,
   output logic              StallE_o,
   output logic              StallM_o,
   output logic              FlushD_o,
   output logic              FlushE_o,
   output logic              FlushW_o,
   output logic [2:0]        ImmSrcD_o,
   output logic [1:0]        PCSrcE_o,
   output logic [3:0]        ALUControlE_o,
   output logic              ALUSrcE_o,
   output logic [1:0]        ForwardAE_o,
   output logic [1:0]        ForwardBE_o,
   output logic              MemWriteM_o,
   output logic              MemReadM_o,
   output logic [1:0]        ResultSrcM_o,
   output logic [1:0]        ResultSrcW_o,
   output logic              RegWriteW_o,
   output logic              MemTimeout_o
);

   localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MEM_TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

   typedef enum logic {S_RUN, S_WAIT} memState_t;

   logic       regWriteD, memWriteD, memReadD, jumpD, jalrD, branchD, aluSrcD, branchOk;
   logic [1:0] resultSrcD;
   logic [3:0] aluOpD, aluCtlD;

   logic       regWriteE, memWriteE, memReadE, jumpE, jalrE, branchE;
   logic [1:0] resultSrcE;
   logic [2:0] funct3E;
   logic       regWriteM;

   logic       memStall, branchCond, takenE, loadUse;
   memState_t  memState;
   logic [CNT_W-1:0] waitCnt;

`ifdef UCSBECE154B_BRANCH_EXT_EN
   assign branchOk = funct3_i[2] | ~funct3_i[1];
`else
   assign branchOk = (funct3_i == 3'b000);
`endif

   always_comb begin
      aluOpD = 4'd0;
      case (funct3_i)
         3'b000: aluOpD = (funct7b5_i & op_i[5]) ? 4'd1 : 4'd0;
         3'b001: aluOpD = 4'd7;
         3'b010: aluOpD = 4'd5;
         3'b011: aluOpD = 4'd6;
         3'b100: aluOpD = 4'd4;
         3'b101: aluOpD = funct7b5_i ? 4'd9 : 4'd8;
         3'b110: aluOpD = 4'd3;
         3'b111: aluOpD = 4'd2;
         default: aluOpD = 4'd0;
      endcase
   end

   // Anything not recognised falls through with all-zero controls, i.e. a bubble.
   always_comb begin
      regWriteD  = 1'b0;
      resultSrcD = 2'b00;
      memWriteD  = 1'b0;
      memReadD   = 1'b0;
      jumpD      = 1'b0;
      jalrD      = 1'b0;
      branchD    = 1'b0;
      aluSrcD    = 1'b0;
      aluCtlD    = 4'd0;
      ImmSrcD_o  = 3'b000;
      case (op_i)
         7'b0000011: if (funct3_i == 3'b010) begin
            regWriteD = 1'b1; resultSrcD = 2'b01; memReadD = 1'b1; aluSrcD = 1'b1;
         end
         7'b0100011: if (funct3_i == 3'b010) begin
            memWriteD = 1'b1; aluSrcD = 1'b1; ImmSrcD_o = 3'b001;
         end
         7'b0110011, 7'b0010011: begin
            regWriteD = 1'b1; aluSrcD = ~op_i[5]; aluCtlD = aluOpD;
         end
         7'b1100011: if (branchOk) begin
            branchD = 1'b1; aluCtlD = 4'd1; ImmSrcD_o = 3'b010;
         end
         7'b1101111: begin
            regWriteD = 1'b1; resultSrcD = 2'b10; jumpD = 1'b1; ImmSrcD_o = 3'b011;
         end
         7'b1100111: if (funct3_i == 3'b000) begin
            regWriteD = 1'b1; resultSrcD = 2'b10; jumpD = 1'b1; jalrD = 1'b1; aluSrcD = 1'b1;
         end
         7'b0110111: begin
            regWriteD = 1'b1; resultSrcD = 2'b11; ImmSrcD_o = 3'b100;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset || (!StallE_o && FlushE_o)) begin
         regWriteE <= 1'b0; resultSrcE <= 2'b00; memWriteE <= 1'b0; memReadE <= 1'b0;
         jumpE <= 1'b0; jalrE <= 1'b0; branchE <= 1'b0; funct3E <= 3'b000;
         ALUControlE_o <= 4'd0; ALUSrcE_o <= 1'b0;
      end else if (!StallE_o) begin
         regWriteE <= regWriteD; resultSrcE <= resultSrcD; memWriteE <= memWriteD; memReadE <= memReadD;
         jumpE <= jumpD; jalrE <= jalrD; branchE <= branchD; funct3E <= funct3_i;
         ALUControlE_o <= aluCtlD; ALUSrcE_o <= aluSrcD;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         regWriteM <= 1'b0; ResultSrcM_o <= 2'b00; MemWriteM_o <= 1'b0; MemReadM_o <= 1'b0;
      end else if (!StallM_o) begin
         regWriteM <= regWriteE; ResultSrcM_o <= resultSrcE; MemWriteM_o <= memWriteE; MemReadM_o <= memReadE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || FlushW_o) begin
         RegWriteW_o <= 1'b0; ResultSrcW_o <= 2'b00;
      end else begin
         RegWriteW_o <= regWriteM; ResultSrcW_o <= ResultSrcM_o;
      end
   end

   assign ForwardAE_o = ((Rs1E_i != '0) && regWriteM   && (RdM_i == Rs1E_i)) ? 2'b10 :
                        ((Rs1E_i != '0) && RegWriteW_o && (RdW_i == Rs1E_i)) ? 2'b01 : 2'b00;
   assign ForwardBE_o = ((Rs2E_i != '0) && regWriteM   && (RdM_i == Rs2E_i)) ? 2'b10 :
                        ((Rs2E_i != '0) && RegWriteW_o && (RdW_i == Rs2E_i)) ? 2'b01 : 2'b00;

`ifdef UCSBECE154B_BRANCH_EXT_EN
   always_comb begin
      branchCond = 1'b0;
      case (funct3E)
         3'b000: branchCond = ZeroE_i;
         3'b001: branchCond = ~ZeroE_i;
         3'b100: branchCond = LtE_i;
         3'b101: branchCond = ~LtE_i;
         3'b110: branchCond = LtuE_i;
         3'b111: branchCond = ~LtuE_i;
         default: branchCond = 1'b0;
      endcase
   end
`else
   logic unusedLt;
   assign unusedLt   = LtE_i ^ LtuE_i;
   assign branchCond = (funct3E == 3'b000) & ZeroE_i;
`endif

   assign takenE   = jumpE | (branchE & branchCond);
   assign memStall = (MemReadM_o | MemWriteM_o) & ~DMemReady_i;
   assign loadUse  = (resultSrcE == 2'b01) && (RdE_i != '0) && ((Rs1D_i == RdE_i) || (Rs2D_i == RdE_i));

   // A memory wait freezes everything up to M and hides any redirect until the access completes.
   always_comb begin
      StallF_o = 1'b0; StallD_o = 1'b0; StallE_o = 1'b0; StallM_o = 1'b0;
      FlushD_o = 1'b0; FlushE_o = 1'b0; FlushW_o = 1'b0;
      PCSrcE_o = 2'b00;
      if (memStall) begin
         StallF_o = 1'b1; StallD_o = 1'b1; StallE_o = 1'b1; StallM_o = 1'b1;
         FlushW_o = 1'b1;
      end else if (takenE) begin
         FlushD_o = 1'b1; FlushE_o = 1'b1;
         PCSrcE_o = jalrE ? 2'b10 : 2'b01;
      end else if (loadUse) begin
         StallF_o = 1'b1; StallD_o = 1'b1; FlushE_o = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         memState     <= S_RUN;
         waitCnt      <= '0;
         MemTimeout_o <= 1'b0;
      end else begin
         case (memState)
            S_RUN: if (memStall) begin
               memState <= S_WAIT;
               waitCnt  <= CNT_W'(1);
            end
            S_WAIT: if (DMemReady_i) begin
               memState <= S_RUN;
               waitCnt  <= '0;
            end else if (memStall && (waitCnt != CNT_MAX)) begin
               waitCnt <= waitCnt + 1'b1;
               if (waitCnt == CNT_LAST) MemTimeout_o <= 1'b1;
            end
            default: memState <= S_RUN;
         endcase
      end
   end

endmodule
